// File: rtl/mem_port_arbiter_if.sv
// Requester/adaptor bundle for mem_port_arbiter: slave is the arbiter's view,
// master is the view of the caches plus cacheline adaptor around it.
interface mem_port_arbiter_if #(
   parameter int NUM_PORTS = 2,
   parameter int LINE_W    = 256,
   parameter int ADDR_W    = 32
) ();
   localparam int IDX_W = $clog2(NUM_PORTS);

   logic [NUM_PORTS-1:0]        port_read;
   logic [NUM_PORTS-1:0]        port_write;
   logic [NUM_PORTS*ADDR_W-1:0] port_addr;
   logic [NUM_PORTS*LINE_W-1:0] port_wdata;
   logic [LINE_W-1:0]           port_rdata;
   logic [NUM_PORTS-1:0]        port_resp;

   logic [LINE_W-1:0]           mem_rdata;
   logic                        mem_resp;
   logic                        mem_read;
   logic                        mem_write;
   logic [ADDR_W-1:0]           mem_address;
   logic [LINE_W-1:0]           mem_wdata;

   logic                        grant_valid;
   logic [IDX_W-1:0]            grant_idx;

   modport slave (
      input  port_read, port_write, port_addr, port_wdata, mem_rdata, mem_resp,
      output port_rdata, port_resp, mem_read, mem_write, mem_address, mem_wdata,
      output grant_valid, grant_idx
   );

   modport master (
      output port_read, port_write, port_addr, port_wdata, mem_rdata, mem_resp,
      input  port_rdata, port_resp, mem_read, mem_write, mem_address, mem_wdata,
      input  grant_valid, grant_idx
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter of NUM_PORTS line requesters onto one adaptor port; grant one
// cycle after request, response passed through combinationally, grant held until mem_resp.
module mem_port_arbiter #(
   parameter int NUM_PORTS = 2,
   parameter int LINE_W    = 256,
   parameter int ADDR_W    = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   mem_port_arbiter_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_PORTS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'b01,
      BUSY = 2'b10
   } state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic             grant_valid_q, grant_valid_d;

   logic [NUM_PORTS-1:0] req;
   logic                 pick_vld;
   logic [IDX_W-1:0]     pick_idx;
   logic [IDX_W-1:0]     next_ptr;

   assign req = bus.port_read | bus.port_write;

   // Scan from farthest to nearest so the requester closest to rr_ptr wins.
   always_comb begin : rr_pick
      int cand;
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = 0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         cand = int'(rr_ptr_q) + i;
         if (cand >= NUM_PORTS) begin
            cand = cand - NUM_PORTS;
         end
         if (req[IDX_W'(cand)]) begin
            pick_vld = 1'b1;
            pick_idx = IDX_W'(cand);
         end
      end
   end

   assign next_ptr = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + IDX_W'(1);

   always_comb begin : fsm_next
      state_d         = state_q;
      grant_idx_d     = grant_idx_q;
      rr_ptr_d        = rr_ptr_q;
      bus.mem_read    = 1'b0;
      bus.mem_write   = 1'b0;
      bus.mem_address = '0;
      bus.mem_wdata   = '0;
      bus.port_resp   = '0;

      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               state_d     = BUSY;
               grant_idx_d = pick_idx;
            end
         end
         BUSY: begin
            // Write wins so the adaptor never sees read and write together.
            bus.mem_write   = bus.port_write[grant_idx_q];
            bus.mem_read    = bus.port_read[grant_idx_q] & ~bus.port_write[grant_idx_q];
            bus.mem_address = bus.port_addr[int'(grant_idx_q)*ADDR_W +: ADDR_W];
            bus.mem_wdata   = bus.port_wdata[int'(grant_idx_q)*LINE_W +: LINE_W];
            bus.port_resp[grant_idx_q] = bus.mem_resp;
            if (bus.mem_resp) begin
               state_d  = IDLE;
               rr_ptr_d = next_ptr;
            end else if (!req[grant_idx_q]) begin
               // Abandoned request: release without advancing fairness pointer.
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign grant_valid_d = (state_d == BUSY);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         grant_idx_q   <= '0;
         rr_ptr_q      <= '0;
         grant_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_idx_q   <= grant_idx_d;
         rr_ptr_q      <= rr_ptr_d;
         grant_valid_q <= grant_valid_d;
      end
   end

   assign bus.grant_valid = grant_valid_q;
   assign bus.grant_idx   = grant_idx_q;
   assign bus.port_rdata  = bus.mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios followed by random traffic, every cycle compared against a
// transaction-level round-robin model.
module tb_mem_port_arbiter;
   localparam int NP = 4;
   localparam int LW = 256;
   localparam int AW = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.NUM_PORTS(NP), .LINE_W(LW), .ADDR_W(AW)) bus ();

   mem_port_arbiter #(.NUM_PORTS(NP), .LINE_W(LW), .ADDR_W(AW)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: whether a grant is held, to whom, and where the next scan starts.
   bit m_busy    = 1'b0;
   int m_g       = 0;
   int m_rr      = 0;
   int last_resp = -1;

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic req_of(input int p);
      return bus.port_read[p] | bus.port_write[p];
   endfunction

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] v;
      v = '0;
      for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic model_reset();
      m_busy = 1'b0;
      m_g    = 0;
      m_rr   = 0;
   endtask

   task automatic model_clock();
      bit found;
      int p;
      last_resp = -1;
      found     = 1'b0;
      if (!m_busy) begin
         for (int k = 0; k < NP; k++) begin
            p = (m_rr + k) % NP;
            if (!found && req_of(p)) begin
               found  = 1'b1;
               m_busy = 1'b1;
               m_g    = p;
            end
         end
      end else if (bus.mem_resp) begin
         last_resp = m_g;
         m_busy    = 1'b0;
         m_rr      = (m_g + 1) % NP;
      end else if (!req_of(m_g)) begin
         m_busy = 1'b0;
      end
   endtask

   task automatic sample(input string ctx);
      logic          e_w, e_r;
      logic [AW-1:0] e_a;
      logic [LW-1:0] e_wd;
      logic [NP-1:0] e_resp;
      @(negedge clk);
      e_w = 1'b0; e_r = 1'b0; e_a = '0; e_wd = '0; e_resp = '0;
      if (m_busy) begin
         e_w         = bus.port_write[m_g];
         e_r         = bus.port_read[m_g] & ~bus.port_write[m_g];
         e_a         = bus.port_addr[m_g*AW +: AW];
         e_wd        = bus.port_wdata[m_g*LW +: LW];
         e_resp[m_g] = bus.mem_resp;
      end
      chk({ctx, ".mem_read"},    LW'(bus.mem_read),    LW'(e_r));
      chk({ctx, ".mem_write"},   LW'(bus.mem_write),   LW'(e_w));
      chk({ctx, ".mem_address"}, LW'(bus.mem_address), LW'(e_a));
      chk({ctx, ".mem_wdata"},   bus.mem_wdata,        e_wd);
      chk({ctx, ".port_resp"},   LW'(bus.port_resp),   LW'(e_resp));
      chk({ctx, ".port_rdata"},  bus.port_rdata,       bus.mem_rdata);
      chk({ctx, ".grant_valid"}, LW'(bus.grant_valid), LW'(m_busy));
      chk({ctx, ".grant_idx"},   LW'(bus.grant_idx),   LW'(m_g));
   endtask

   task automatic advance();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic clear_ports();
      bus.port_read  = '0;
      bus.port_write = '0;
      bus.mem_resp   = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst.grant_valid", LW'(bus.grant_valid), LW'(0));
      chk("rst.grant_idx",   LW'(bus.grant_idx),   LW'(0));
      chk("rst.mem_read",    LW'(bus.mem_read),    LW'(0));
      chk("rst.port_resp",   LW'(bus.port_resp),   LW'(0));
      model_reset();
      #1;
      rst_n = 1'b1;
   endtask

   bit            act [NP];
   int            kind;
   logic [LW-1:0] rd_line;

   initial begin
      bus.port_read  = '0;
      bus.port_write = '0;
      bus.port_addr  = '0;
      bus.port_wdata = '0;
      bus.mem_rdata  = '0;
      bus.mem_resp   = 1'b0;
      model_reset();

      // Power-on reset
      #3;
      chk("por.grant_valid", LW'(bus.grant_valid), LW'(0));
      chk("por.grant_idx",   LW'(bus.grant_idx),   LW'(0));
      chk("por.mem_write",   LW'(bus.mem_write),   LW'(0));
      #9 rst_n = 1'b1;
      advance();

      // Single port read, response after 4 busy cycles
      bus.port_read       = 4'b0001;
      bus.port_addr[0+:AW] = 32'h0000_1000;
      rd_line             = rand_line();
      bus.mem_rdata       = rd_line;
      sample("sp0"); advance();
      for (int c = 1; c <= 3; c++) begin
         sample("spb");
         chk("sp.mem_read", LW'(bus.mem_read), LW'(1));
         chk("sp.no_resp",  LW'(bus.port_resp), LW'(0));
         advance();
      end
      bus.mem_resp = 1'b1;
      sample("sp4");
      chk("sp.addr",   LW'(bus.mem_address), LW'(32'h1000));
      chk("sp.resp",   LW'(bus.port_resp),   LW'(4'b0001));
      chk("sp.rdata",  bus.port_rdata,       rd_line);
      advance();
      clear_ports();
      sample("sp5");
      chk("sp.idle", LW'(bus.grant_valid), LW'(0));
      advance();

      // Fairness: all ports read continuously, 2-cycle transactions
      do_reset();
      bus.port_read = '1;
      for (int n = 0; n < 8; n++) begin
         sample("fair_idle"); advance();
         bus.port_read = '1;
         sample("fair_b1");
         chk("fair.grant", LW'(bus.grant_idx), LW'(n % NP));
         advance();
         bus.mem_resp = 1'b1;
         sample("fair_b2");
         chk("fair.resp", LW'(bus.port_resp), LW'(1 << (n % NP)));
         advance();
         bus.mem_resp = 1'b0;
         bus.port_read[n % NP] = 1'b0;
      end
      clear_ports();
      sample("fair_end"); advance();

      // Lock: port 1 holds the grant while port 0 starts requesting
      do_reset();
      bus.port_read         = 4'b0010;
      bus.port_addr[AW+:AW] = $urandom;
      sample("lk0"); advance();
      bus.port_read = 4'b0011;
      for (int c = 0; c < 2; c++) begin
         sample("lkb");
         chk("lk.hold", LW'(bus.grant_idx), LW'(1));
         advance();
      end
      bus.mem_resp = 1'b1;
      sample("lkr");
      chk("lk.resp", LW'(bus.port_resp), LW'(4'b0010));
      advance();
      bus.mem_resp  = 1'b0;
      bus.port_read = 4'b0001;
      sample("lki");
      chk("lk.turn", LW'(bus.grant_valid), LW'(0));
      advance();
      sample("lkg");
      chk("lk.grant0", LW'(bus.grant_idx), LW'(0));
      chk("lk.read0",  LW'(bus.mem_read),  LW'(1));
      bus.mem_resp = 1'b1;
      advance();
      clear_ports();
      sample("lk_end"); advance();

      // Write priority over read on the same port
      bus.port_read        = 4'b0001;
      bus.port_write       = 4'b0001;
      bus.port_wdata[0+:LW] = {32{8'hA5}};
      sample("wp0"); advance();
      sample("wp1");
      chk("wp.write", LW'(bus.mem_write), LW'(1));
      chk("wp.read",  LW'(bus.mem_read),  LW'(0));
      chk("wp.wdata", bus.mem_wdata, {32{8'hA5}});
      bus.mem_resp = 1'b1;
      advance();
      clear_ports();
      sample("wp_end"); advance();

      // Abandon: port 2 drops its request without a response
      bus.port_read = 4'b0100;
      sample("ab0"); advance();
      sample("ab1");
      chk("ab.grant", LW'(bus.grant_idx), LW'(2));
      advance();
      bus.port_read = '0;
      sample("ab2");
      chk("ab.no_resp", LW'(bus.port_resp), LW'(0));
      advance();
      bus.port_read = 4'b0011;
      sample("ab3");
      chk("ab.idle", LW'(bus.grant_valid), LW'(0));
      advance();
      sample("ab4");
      chk("ab.rr_kept", LW'(bus.grant_idx), LW'(1));
      bus.mem_resp = 1'b1;
      advance();
      clear_ports();
      sample("ab_end"); advance();

      // Reset in the middle of a read, with mem_resp high
      bus.port_read = 4'b1000;
      sample("mr0"); advance();
      sample("mr1");
      chk("mr.busy_read", LW'(bus.mem_read), LW'(1));
      advance();
      bus.mem_resp = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      chk("mr.mem_read",    LW'(bus.mem_read),    LW'(0));
      chk("mr.port_resp",   LW'(bus.port_resp),   LW'(0));
      chk("mr.grant_valid", LW'(bus.grant_valid), LW'(0));
      chk("mr.grant_idx",   LW'(bus.grant_idx),   LW'(0));
      model_reset();
      bus.mem_resp  = 1'b0;
      bus.port_read = 4'b0101;
      #1 rst_n = 1'b1;
      sample("mr2"); advance();
      sample("mr3");
      chk("mr.port0_wins", LW'(bus.grant_idx), LW'(0));
      bus.mem_resp = 1'b1;
      advance();
      clear_ports();
      sample("mr_end"); advance();

      // Random traffic honouring the port contract
      for (int p = 0; p < NP; p++) act[p] = 1'b0;
      last_resp = -1;
      for (int cyc = 0; cyc < 800; cyc++) begin
         if (last_resp >= 0) begin
            act[last_resp]            = 1'b0;
            bus.port_read[last_resp]  = 1'b0;
            bus.port_write[last_resp] = 1'b0;
         end
         for (int p = 0; p < NP; p++) begin
            if (p == last_resp) continue;
            if (!act[p]) begin
               if ($urandom_range(3) == 0) begin
                  act[p] = 1'b1;
                  kind   = $urandom_range(2);
                  bus.port_read[p]          = (kind != 1);
                  bus.port_write[p]         = (kind != 0);
                  bus.port_addr[p*AW +: AW] = $urandom;
                  bus.port_wdata[p*LW +: LW] = rand_line();
               end
            end else if ($urandom_range(39) == 0) begin
               act[p]            = 1'b0;
               bus.port_read[p]  = 1'b0;
               bus.port_write[p] = 1'b0;
            end
         end
         bus.mem_rdata = rand_line();
         bus.mem_resp  = m_busy && req_of(m_g) && ($urandom_range(2) == 0);
         sample("rnd");
         advance();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Parametrised round-robin arbiter that multiplexes NUM_PORTS cache-line requesters (I-cache, D-cache, prefetcher, ...) onto the single cacheline adaptor port. It sits between the caches and the adaptor. It replaces fixed-priority two-cache arbitration with fair rotation, a lock-until-response grant and grant observability for performance counters.

## Interface
- NUM_PORTS, 2, number of requesters (≥2); IDX_W = $clog2(NUM_PORTS)
- LINE_W, 256, cache line width in bits
- ADDR_W, 32, address width in bits
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- port_read  in  NUM_PORTS  per-port line read request
- port_write  in  NUM_PORTS  per-port line write request
- port_addr  in  NUM_PORTS*ADDR_W  per-port address; port i at bits [i*ADDR_W +: ADDR_W]
- port_wdata  in  NUM_PORTS*LINE_W  per-port write data; port i at bits [i*LINE_W +: LINE_W]
- port_rdata  out  LINE_W  read data, broadcast to all ports, equals mem_rdata
- port_resp  out  NUM_PORTS  one-hot response; only the granted bit may be high
- mem_rdata  in  LINE_W  adaptor read data
- mem_resp  in  1  adaptor completion
- mem_read  out  1  adaptor read
- mem_write  out  1  adaptor write
- mem_address  out  ADDR_W  adaptor address
- mem_wdata  out  LINE_W  adaptor write data
- grant_valid  out  1  high while in BUSY
- grant_idx  out  IDX_W  index of the granted port; holds the last grant when idle

## Operation
- Registered state: fsm {IDLE, BUSY}, grant_idx, rr_ptr (IDX_W).
- A port requests when port_read[i] | port_write[i].
- IDLE: if any port requests, select the first requester scanning rr_ptr, rr_ptr+1, ... with wrap at NUM_PORTS-1 → 0. Latch grant_idx and go to BUSY. With no requests, stay in IDLE.
- BUSY, combinational pass-through from port g = grant_idx:
  - mem_write = port_write[g]
  - mem_read = port_read[g] & ~port_write[g]; write has priority, so a read is never issued alongside a write
  - mem_address = port_addr[g]; mem_wdata = port_wdata[g]
  - port_resp[g] = mem_resp; all other port_resp bits 0
- BUSY exit:
  - mem_resp=1: go to IDLE; rr_ptr ← (g+1) wrapped to 0 after NUM_PORTS-1.
  - Granted port drops both requests without a response (abandon): go to IDLE; rr_ptr unchanged.
  - Requests from other ports are ignored until the grant ends.
- IDLE outputs: mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, port_resp=0.
- port_rdata = mem_rdata in every state; ports qualify it with their own port_resp bit.
- Port contract: hold the request and its address/data stable until port_resp; drop the request in the cycle after port_resp.
- Reset (rst=0, asynchronous, also mid-transaction): fsm=IDLE, grant_idx=0, rr_ptr=0, grant_valid=0. All mem_* and port_resp outputs are 0 immediately. An in-flight adaptor transaction is abandoned, and the adaptor is reset together with the arbiter.
- Unreachable fsm encodings return to IDLE.

## Timing
- Grant latency: request seen in IDLE at cycle t → mem_read/mem_write high at cycle t+1.
- Response path is combinational, zero cycles: mem_resp → port_resp.
- One-cycle IDLE turnaround after every response. Back-to-back transactions are therefore spaced as follows: mem_resp at cycle k, IDLE at k+1, next mem_read/mem_write at k+2.
- Worst-case wait for a continuously requesting port: NUM_PORTS-1 complete transactions.
- grant_valid and grant_idx are registered and glitch-free; they are used directly by performance counters.

## Test plan
- Single port: NUM_PORTS=2, port_read=2'b01, port_addr[0]=0x0000_1000, mem_resp after 4 BUSY cycles → mem_read high cycles 1–4, mem_address=0x1000, port_resp=2'b01 in cycle 4 only, port_rdata=mem_rdata, IDLE in cycle 5.
- Fairness: NUM_PORTS=4, all ports read continuously, each transaction 2 cycles → grant_idx sequence 0,1,2,3,0,…; no port is granted twice before all others have been served.
- Lock: port 1 granted, port 0 asserts a read mid-transaction → grant_idx stays 1 until mem_resp; port 0 is granted at mem_resp+2 with rr_ptr=2 and only port 0 requesting.
- Write priority: port 0 asserts read and write together with wdata=256'hA5… → mem_write=1, mem_read=0, mem_wdata matches the port data.
- Abandon: granted port 2 drops its request with no mem_resp → next cycle IDLE, rr_ptr unchanged, port_resp never asserted.
- Reset mid-transaction: rst low during BUSY with mem_read=1 → mem_read, port_resp and grant_valid go 0 without waiting for a clock edge; after release, grant_idx=0 and rr_ptr=0, so port 0 wins simultaneous requests.
